// File: rtl/uart_pkg.sv
// Shared types and constants for the interconn UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   UART_DATA_W     = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Ceiling log2, used to size counters from parameters.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/interconn_uart_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART serialiser.
module interconn_uart_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_rd_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_level
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rd_data = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/interconn_uart_tx.sv
// FPGA-side 8N1 UART transmitter onto the interconn line; define
// UART_TX_PARITY_EN to append an even parity bit after the data bits.
module interconn_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx_line,
    output logic                   busy,
    output logic [FIFO_AW:0]       fifo_level
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam int IDX_W = clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_busy;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_bit_tick;
    logic [UART_DATA_W-1:0] w_rd_data;
    logic [FIFO_AW:0]       w_level;

    assign w_push     = in_valid && !w_full;
    assign w_bit_tick = (r_cnt == CNT_LAST);
    assign in_ready   = !w_full;
    assign tx_line    = r_tx;
    assign busy       = r_busy;
    assign fifo_level = w_level;

    interconn_uart_fifo #(
        .WIDTH   (UART_DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data (in_data),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Even parity is captured whole at pop time, before the byte is shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_rd_data;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_bit_tick ? '0 : r_cnt + 1'b1;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        w_tx_next    = UART_IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_rd_data;
                    w_idx_next   = '0;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_bit_tick) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_tick) begin
                    w_shift_next = r_shift >> 1;
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_tx_next = r_parity;
                if (w_bit_tick) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                w_tx_next = UART_IDLE_LEVEL;
                if (w_bit_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Every state entry restarts the bit timer.
        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= UART_IDLE_LEVEL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            r_busy  <= (r_state != IDLE) || (w_level != '0);
        end
    end

endmodule

// File: doc/interconn_uart_tx.md
Name: interconn_uart_tx

Overview:
- FPGA-side UART transmitter. It serialises bytes from the CPU/bus onto the interconn line that the CPLD forwards to the board txd pin.
- Bytes enter through a valid/ready handshake and are buffered in a small FIFO.
- Each byte is sent as 8N1 (one start bit, 8 data bits LSB first, one stop bit), with optional even parity.
- Sits next to the existing FPGA-side UART receiver, which consumes the CPLD-forwarded rxd line.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, CLK_HZ/BAUD (integer, truncated), clocks per bit; must be >= 2.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to send.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a byte.
- tx_line  out  1  serial output to interconn; idles high.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- **Clocking and reset:** one clock; reset is asynchronous and active-low (clk, rst_n). All state is cleared on rst_n low.
- **Reset values:** tx_line=1, in_ready=1, busy=0, fifo_level=0, state=IDLE.
- **Input handshake:** a push occurs when in_valid && in_ready at a clk rising edge.
  - in_ready = !full, registered-state only. No combinational path from in_valid or from the same-cycle pop.
  - Push while full is impossible by construction. in_data is ignored when no push occurs.
- **FIFO:** circular buffer, pointers FIFO_AW+1 bits wide, wrap-around via the MSB.
  - Simultaneous push and pop: level unchanged, both take effect.
  - Pop on empty never occurs.
- **Baud counter:** counts 0..DIV-1 and restarts at 0 on every state entry. bit_tick = (cnt==DIV-1).
- **FSM:**
  - IDLE: tx_line=1. If FIFO non-empty, pop into shift register, go to START. The pop and the transition occur in the same cycle.
  - START: tx_line=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: tx_line=shift[0]. On bit_tick, shift right and increment the index; after index 7 completes, go to PARITY (if enabled) or STOP.
  - STOP: tx_line=1 for DIV clocks. On bit_tick, return to IDLE.
- **Frame timing:**
  - tx_line goes low one clock after the IDLE pop edge.
  - One frame = 10*DIV clocks (11*DIV with parity).
  - Back-to-back bytes: IDLE holds for exactly 1 clock between STOP end and the next START.
- **Output register:** tx_line is registered (glitch-free, since it drives an inter-chip pin).
- **busy:** registered, = (state!=IDLE) || (level!=0).
- **Mid-frame reset:** tx_line returns to 1 asynchronously, the FIFO is flushed, and the partial frame is abandoned.
- **Overflow:** no overflow or underflow flags are required; the handshake prevents both.

Optional Feature:
- Macro UART_TX_PARITY_EN.
  - **Defined:** a PARITY state follows DATA. tx_line = XOR of the 8 data bits (even parity) for DIV clocks; frame length is 11*DIV.
  - **Undefined:** no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- **Package uart_pkg:**
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_W=8;
  - UART_IDLE_LEVEL=1'b1;
  - function clog2 for counter widths.
- **Sub-module interconn_uart_fifo:** synchronous FIFO with push/pop/full/empty/level, parameterised by width and FIFO_AW. The top module keeps the FSM and baud counter.

Test Plan (CLK_HZ=40, BAUD=10 so DIV=4, FIFO_AW=2, unless stated):
- Reset then idle for 100 clk -> tx_line=1, busy=0, in_ready=1 throughout.
- Push 8'hA5 -> tx_line is 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 for 4 clk each, then 1 for 4 clk. Total 40 clk; busy falls after STOP.
- Push 5 bytes 8'h01..8'h05 on consecutive cycles -> in_ready drops when level reaches 4 and rises after the first pop. All 5 frames are sent in order with 1 idle clk between frames.
- Assert rst_n low at clk 15 of a frame for 8'hFF -> tx_line is 1 immediately, fifo_level=0. After release, no residual frame is sent.
- Push and pop in the same cycle at level 2 -> level stays 2, data order is preserved.
- With UART_TX_PARITY_EN, push 8'h07 -> parity bit=1, frame is 44 clk. Push 8'h03 -> parity bit=0.
